// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store sequencer in front of the data memory.
package lsu_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2,
    ERR    = 2'd3
  } lsu_state_e;

  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;

  localparam logic [31:0] ADDR_LIMIT_DEF = 32'h0000_3FFF;

  // Bit positions inside the packed width-strobe vector.
  localparam int S_LB  = 0;
  localparam int S_LBU = 1;
  localparam int S_LH  = 2;
  localparam int S_LHU = 3;
  localparam int S_LW  = 4;
  localparam int S_SB  = 5;
  localparam int S_SH  = 6;
  localparam int S_SW  = 7;

endpackage

// File: rtl/lsu_width_dec.sv
// Access-width decoder: direction, funct3 and the low address bits give the
// one-hot mem strobes plus illegal-encoding and misalignment flags.
module lsu_width_dec
  import lsu_pkg::*;
(
  input  logic       is_load,
  input  logic [2:0] funct3,
  input  logic [1:0] ea_lo,
  output logic [7:0] strb,
  output logic       illegal,
  output logic       misaligned
);

  always_comb begin
    strb       = '0;
    illegal    = 1'b0;
    misaligned = 1'b0;
    if (is_load) begin
      case (funct3)
        F3_B:  strb[S_LB]  = 1'b1;
        F3_BU: strb[S_LBU] = 1'b1;
        F3_H:  begin strb[S_LH]  = 1'b1; misaligned = ea_lo[0]; end
        F3_HU: begin strb[S_LHU] = 1'b1; misaligned = ea_lo[0]; end
        F3_W:  begin strb[S_LW]  = 1'b1; misaligned = |ea_lo;   end
        default: illegal = 1'b1;
      endcase
    end else begin
      case (funct3)
        F3_B:  strb[S_SB] = 1'b1;
        F3_H:  begin strb[S_SH] = 1'b1; misaligned = ea_lo[0]; end
        F3_W:  begin strb[S_SW] = 1'b1; misaligned = |ea_lo;   end
        default: illegal = 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store sequencer: one-cycle mem access, then a done pulse with the load result.
// Define LSU_ALIGN_FORCE_EN to force-align misaligned accesses instead of faulting.
module lsu_ctrl
  import lsu_pkg::*;
#(
  parameter int              XLEN       = 32,
  parameter logic [XLEN-1:0] ADDR_LIMIT = ADDR_LIMIT_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            is_load,
  input  logic            is_store,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rs1_val,
  input  logic [XLEN-1:0] imm,
  input  logic [XLEN-1:0] rs2_val,
  output logic            busy,
  output logic            done,
  output logic            fault,
  output logic [XLEN-1:0] rd_data,
  output logic            mem_enabled,
  output logic            mem_load_enable,
  output logic            mem_store_enable,
  output logic            mem_is_lb,
  output logic            mem_is_lbu,
  output logic            mem_is_lh,
  output logic            mem_is_lhu,
  output logic            mem_is_lw,
  output logic            mem_is_sb,
  output logic            mem_is_sh,
  output logic            mem_is_sw,
  output logic [XLEN-1:0] mem_address,
  output logic [XLEN-1:0] mem_data_in,
  input  logic [XLEN-1:0] mem_data_out
);

  lsu_state_e      state_reg, state_next;
  logic [XLEN-1:0] ea_reg, rs2_reg, rd_data_reg;
  logic [7:0]      strb_reg;
  logic            is_load_reg, done_reg, fault_reg;

  logic [XLEN-1:0] ea_next, ea_capture;
  logic [7:0]      dec_strb, strb_out;
  logic            dec_illegal, dec_misaligned, range_err, req_fault, req_valid;
  logic            in_access;

  assign ea_next   = rs1_val + imm;
  assign req_valid = is_load | is_store;
  assign range_err = ea_next > ADDR_LIMIT;

  // Loads win when both direction bits are set, so the decoder sees is_load directly.
  lsu_width_dec u_width_dec (
    .is_load    (is_load),
    .funct3     (funct3),
    .ea_lo      (ea_next[1:0]),
    .strb       (dec_strb),
    .illegal    (dec_illegal),
    .misaligned (dec_misaligned)
  );

`ifdef LSU_ALIGN_FORCE_EN
  logic is_half, is_word;
  assign is_half    = dec_strb[S_LH] | dec_strb[S_LHU] | dec_strb[S_SH];
  assign is_word    = dec_strb[S_LW] | dec_strb[S_SW];
  assign req_fault  = dec_illegal | range_err;
  assign ea_capture = ea_next & {{(XLEN-2){1'b1}}, ~is_word, ~(is_word | is_half)};
  logic unused_mis;
  assign unused_mis = dec_misaligned;
`else
  assign req_fault  = dec_illegal | dec_misaligned | range_err;
  assign ea_capture = ea_next;
`endif

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start && req_valid) state_next = req_fault ? ERR : ACCESS;
      ACCESS:  state_next = RESP;
      RESP:    state_next = IDLE;
      ERR:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      ea_reg      <= '0;
      rs2_reg     <= '0;
      strb_reg    <= '0;
      is_load_reg <= 1'b0;
      done_reg    <= 1'b0;
      fault_reg   <= 1'b0;
      rd_data_reg <= '0;
    end else begin
      state_reg <= state_next;
      done_reg  <= 1'b0;
      fault_reg <= 1'b0;
      case (state_reg)
        IDLE: if (start && req_valid) begin
          ea_reg      <= ea_capture;
          rs2_reg     <= rs2_val;
          strb_reg    <= dec_strb;
          is_load_reg <= is_load;
        end
        RESP: begin
          done_reg <= 1'b1;
          if (is_load_reg) rd_data_reg <= mem_data_out;
        end
        ERR: begin
          done_reg  <= 1'b1;
          fault_reg <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign in_access = (state_reg == ACCESS);

  // Every mem-side output is gated by ACCESS so it drops with the async reset.
  for (genvar gi = 0; gi < 8; gi++) begin : g_strb
    assign strb_out[gi] = in_access & strb_reg[gi];
  end

  assign mem_is_lb  = strb_out[S_LB];
  assign mem_is_lbu = strb_out[S_LBU];
  assign mem_is_lh  = strb_out[S_LH];
  assign mem_is_lhu = strb_out[S_LHU];
  assign mem_is_lw  = strb_out[S_LW];
  assign mem_is_sb  = strb_out[S_SB];
  assign mem_is_sh  = strb_out[S_SH];
  assign mem_is_sw  = strb_out[S_SW];

  assign mem_enabled      = in_access;
  assign mem_load_enable  = in_access & is_load_reg;
  assign mem_store_enable = in_access & ~is_load_reg;
  assign mem_address      = in_access ? ea_reg  : '0;
  assign mem_data_in      = in_access ? rs2_reg : '0;

  assign busy    = (state_reg != IDLE);
  assign done    = done_reg;
  assign fault   = fault_reg;
  assign rd_data = rd_data_reg;

endmodule
